// File: rtl/rcpu_io_pkg.sv
// rcpu I/O map shared by the bus peripherals: one-hot address bit indices
// (bit 0 is the MSB) plus the SPI master status-word layout and FSM states.
package rcpu_io_pkg;

    localparam int IO_PMOD_BIT = 2;
    localparam int IO_LED_BIT  = 12;
    localparam int IO_UART_BIT = 13;
    localparam int IO_DATA_BIT = 14;
    localparam int IO_CTRL_BIT = 15;

    localparam int STAT_CS_BIT      = 12;
    localparam int STAT_OVERRUN_BIT = 13;
    localparam int STAT_DONE_BIT    = 14;
    localparam int STAT_BUSY_BIT    = 15;

    typedef enum logic [1:0] {
        SPI_IDLE = 2'd0,
        SPI_LOW  = 2'd1,
        SPI_HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-0 MSB-first byte shifter: SCK divider, IDLE/LOW/HIGH FSM, shift
// register and bit counter. Pulses done_pulse on the final SCK fall.
module spi_byte_engine
    import rcpu_io_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sck,
    output logic       mosi,
    output logic       busy,
    output logic       done_pulse,
    output logic [7:0] rx_byte
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    spi_state_e state, state_nxt;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       half_done;

    assign half_done = (div_cnt == DIV_LAST);
    assign busy      = (state != SPI_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        done_pulse = 1'b0;
        case (state)
            SPI_IDLE: begin
                if (start) state_nxt = SPI_LOW;
            end
            SPI_LOW: begin
                if (half_done) state_nxt = SPI_HIGH;
            end
            SPI_HIGH: begin
                if (half_done) begin
                    if (bit_cnt == 3'd7) begin
                        state_nxt  = SPI_IDLE;
                        done_pulse = 1'b1;
                    end else begin
                        state_nxt = SPI_LOW;
                    end
                end
            end
            default: state_nxt = SPI_IDLE;
        endcase
    end

    // MISO shifts in on the rise; the next MOSI bit (now shift[7]) goes out on the fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck     <= 1'b0;
            mosi    <= 1'b0;
            div_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            rx_byte <= 8'h00;
        end else begin
            case (state)
                SPI_IDLE: begin
                    if (start) begin
                        shift   <= tx_byte;
                        mosi    <= tx_byte[7];
                        div_cnt <= 8'd0;
                        bit_cnt <= 3'd0;
                    end
                end
                SPI_LOW: begin
                    if (half_done) begin
                        div_cnt <= 8'd0;
                        sck     <= 1'b1;
                        shift   <= {shift[6:0], miso};
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SPI_HIGH: begin
                    if (half_done) begin
                        div_cnt <= 8'd0;
                        sck     <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            rx_byte <= shift;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            mosi    <= shift[7];
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_io_master.sv
// rcpu I/O-bus SPI master: bus decode, software-owned chip select, done and
// overrun flags, and the combinational read word for the top-level mux.
module spi_io_master
    import rcpu_io_pkg::*;
#(
    parameter int DATA_BIT = IO_DATA_BIT,
    parameter int CTRL_BIT = IO_CTRL_BIT,
    parameter int CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [0:15] io_address,
    input  logic [0:15] io_write_data,
    output logic [0:15] rdata,
    output logic        busy,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    input  logic        spi_miso
);

    logic        wr_data, wr_ctrl, rd_data;
    logic        start, ctrl_clear, done_pulse;
    logic        done, overrun;
    logic [7:0]  rx_byte;
    logic [0:15] status;

    assign wr_data    = io_write_enable & io_address[DATA_BIT];
    assign wr_ctrl    = io_write_enable & io_address[CTRL_BIT];
    assign rd_data    = io_read_enable & io_address[DATA_BIT];
    assign start      = wr_data & ~busy;
    assign ctrl_clear = wr_ctrl & ~busy & io_write_data[14];

    spi_byte_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tx_byte   (io_write_data[8:15]),
        .miso      (spi_miso),
        .sck       (spi_sck),
        .mosi      (spi_mosi),
        .busy      (busy),
        .done_pulse(done_pulse),
        .rx_byte   (rx_byte)
    );

    // Any write during a byte is dropped whole so CS can never move mid-byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            spi_cs_n <= 1'b1;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (wr_ctrl && !busy) spi_cs_n <= ~io_write_data[15];

            if ((wr_data || wr_ctrl) && busy) begin
                overrun <= 1'b1;
            end else if (ctrl_clear) begin
                overrun <= 1'b0;
            end

            if (done_pulse) begin
                done <= 1'b1;
            end else if (rd_data || ctrl_clear || start) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        status                   = '0;
        status[STAT_CS_BIT]      = ~spi_cs_n;
        status[STAT_OVERRUN_BIT] = overrun;
        status[STAT_DONE_BIT]    = done;
        status[STAT_BUSY_BIT]    = busy;
        rdata                    = '0;
        if (io_address[DATA_BIT]) rdata = rdata | {8'd0, rx_byte};
        if (io_address[CTRL_BIT]) rdata = rdata | status;
    end

endmodule

// File: tb/tb_spi_io_master.sv
// Bench for spi_io_master: two instances (CLK_DIV 2 and 1) on a shared bus,
// checked every cycle against a timeline model plus literal expectations.
module tb_spi_io_master;

    localparam int D0 = 2;
    localparam int D1 = 1;
    localparam logic [0:15] A_DATA = 16'h0002;
    localparam logic [0:15] A_CTRL = 16'h0001;
    localparam logic [0:15] A_BOTH = 16'h0003;
    localparam logic [0:15] A_B12  = 16'h0008;
    localparam logic [0:15] A_B2   = 16'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        io_read_enable = 1'b0;
    logic        io_write_enable = 1'b0;
    logic [0:15] io_address = '0;
    logic [0:15] io_write_data = '0;
    logic [0:15] rdata [2];
    logic        busy [2];
    logic        sck [2];
    logic        mosi [2];
    logic        cs_n [2];
    logic        miso [2];

    int          miso_mode = 0;
    logic        rnd_miso = 1'b0;
    logic [7:0]  slave_reg [2];

    int          vectors = 0;
    int          miscompares = 0;
    int          busy_cnt [2] = '{0, 0};
    int          rises [2] = '{0, 0};
    logic        prev_sck [2] = '{1'b0, 1'b0};

    // Model: m_k is the cycle index inside the 16*D busy window, -1 when idle.
    int          m_k [2];
    logic        m_cs_n [2], m_done [2], m_ov [2], m_lmosi [2];
    logic [7:0]  m_rx [2], m_tx [2], m_smp [2];
    bit          m_valid = 1'b0;

    always #5 clk = ~clk;

    assign miso[0] = (miso_mode == 1) ? mosi[0] : (miso_mode == 2) ? slave_reg[0][7] : rnd_miso;
    assign miso[1] = (miso_mode == 1) ? mosi[1] : (miso_mode == 2) ? slave_reg[1][7] : rnd_miso;

    spi_io_master #(.CLK_DIV(D0)) u_dut0 (
        .clk(clk), .reset(reset), .io_read_enable(io_read_enable),
        .io_write_enable(io_write_enable), .io_address(io_address),
        .io_write_data(io_write_data), .rdata(rdata[0]), .busy(busy[0]),
        .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_cs_n(cs_n[0]), .spi_miso(miso[0])
    );

    spi_io_master #(.CLK_DIV(D1)) u_dut1 (
        .clk(clk), .reset(reset), .io_read_enable(io_read_enable),
        .io_write_enable(io_write_enable), .io_address(io_address),
        .io_write_data(io_write_data), .rdata(rdata[1]), .busy(busy[1]),
        .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_cs_n(cs_n[1]), .spi_miso(miso[1])
    );

    task automatic chk(string nm, int inst, logic [15:0] act, logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic chk_bit(string nm, int inst, logic act, logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] got %b expected %b at %0t", nm, inst, act, exp, $time);
        end
    endtask

    function automatic logic miso_of(int i);
        if (miso_mode == 1) return mosi[i];
        if (miso_mode == 2) return slave_reg[i][7];
        return rnd_miso;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int          d;
            int          h;
            logic        eb, es, em, wd, wc, rd, nd, no;
            logic [0:15] er;
            logic [0:15] st;
            d = (i == 0) ? D0 : D1;
            if (prev_sck[i] === 1'b1 && sck[i] === 1'b0) slave_reg[i] = {slave_reg[i][6:0], 1'b0};
            if (prev_sck[i] === 1'b0 && sck[i] === 1'b1) rises[i]++;
            if (busy[i] === 1'b1) busy_cnt[i]++;
            prev_sck[i] = sck[i];

            if (m_valid) begin
                eb = (m_k[i] >= 0);
                h  = eb ? m_k[i] / d : 0;
                es = eb && (h % 2 == 1);
                em = eb ? m_tx[i][7 - h / 2] : m_lmosi[i];
                st = {12'd0, ~m_cs_n[i], m_ov[i], m_done[i], eb};
                er = '0;
                if (io_address[14]) er = er | {8'd0, m_rx[i]};
                if (io_address[15]) er = er | st;
                chk_bit("busy", i, busy[i], eb);
                chk_bit("sck", i, sck[i], es);
                chk_bit("mosi", i, mosi[i], em);
                chk_bit("cs_n", i, cs_n[i], m_cs_n[i]);
                chk("rdata", i, rdata[i], er);
            end

            if (reset) begin
                m_k[i] = -1; m_cs_n[i] = 1'b1; m_done[i] = 1'b0; m_ov[i] = 1'b0;
                m_rx[i] = 8'h00; m_lmosi[i] = 1'b0; m_smp[i] = 8'h00; m_tx[i] = 8'h00;
            end else begin
                wd = io_write_enable && io_address[14];
                wc = io_write_enable && io_address[15];
                rd = io_read_enable && io_address[14];
                nd = m_done[i];
                no = m_ov[i];
                if (rd) nd = 1'b0;
                if (m_k[i] >= 0) begin
                    if (wd || wc) no = 1'b1;
                    if ((m_k[i] % d == d - 1) && ((m_k[i] / d) % 2 == 0))
                        m_smp[i] = {m_smp[i][6:0], miso_of(i)};
                    if (m_k[i] == 16 * d - 1) begin
                        m_rx[i] = m_smp[i];
                        nd = 1'b1;
                        m_lmosi[i] = m_tx[i][0];
                        m_k[i] = -1;
                    end else begin
                        m_k[i]++;
                    end
                end else begin
                    if (wc) begin
                        m_cs_n[i] = ~io_write_data[15];
                        if (io_write_data[14]) begin
                            nd = 1'b0;
                            no = 1'b0;
                        end
                    end
                    if (wd) begin
                        m_tx[i] = io_write_data[8:15];
                        nd = 1'b0;
                        m_k[i] = 0;
                    end
                end
                m_done[i] = nd;
                m_ov[i] = no;
            end
        end
        m_valid = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [0:15] a, logic [0:15] d);
        io_write_enable = 1'b1;
        io_address = a;
        io_write_data = d;
        cyc();
        io_write_enable = 1'b0;
        io_address = '0;
        io_write_data = '0;
    endtask

    task automatic rd_chk(string nm, logic [0:15] a, logic [15:0] e0, logic [15:0] e1);
        io_read_enable = 1'b1;
        io_address = a;
        #1;
        chk(nm, 0, rdata[0], e0);
        chk(nm, 1, rdata[1], e1);
        cyc();
        io_read_enable = 1'b0;
        io_address = '0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((busy[0] !== 1'b0 || busy[1] !== 1'b0) && n < budget) begin
            cyc();
            n++;
        end
        if (busy[0] !== 1'b0 || busy[1] !== 1'b0) chk_bit("idle_timeout", 0, 1'b1, 1'b0);
    endtask

    initial begin
        int b0 [2];
        int r0 [2];
        int f0, f1;
        logic [0:15] addr_tab [7];

        cyc(); cyc(); cyc();
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 2; i++) begin
            chk_bit("rst_sck", i, sck[i], 1'b0);
            chk_bit("rst_cs_n", i, cs_n[i], 1'b1);
            chk_bit("rst_busy", i, busy[i], 1'b0);
        end
        rd_chk("rst_status", A_CTRL, 16'h0000, 16'h0000);

        // Reset in the middle of a byte.
        wr(A_CTRL, 16'h0001);
        wr(A_DATA, 16'h005A);
        repeat (6) cyc();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_bit("abort_sck", i, sck[i], 1'b0);
            chk_bit("abort_cs_n", i, cs_n[i], 1'b1);
            chk_bit("abort_busy", i, busy[i], 1'b0);
            r0[i] = rises[i];
        end
        repeat (4) cyc();
        for (int i = 0; i < 2; i++) chk("abort_no_sck", i, 16'(rises[i] - r0[i]), 16'd0);
        rd_chk("abort_status", A_CTRL, 16'h0000, 16'h0000);
        rd_chk("abort_rx", A_DATA, 16'h0000, 16'h0000);

        // Loopback A5.
        miso_mode = 1;
        wr(A_CTRL, 16'h0001);
        for (int i = 0; i < 2; i++) begin
            chk_bit("lb_cs_n", i, cs_n[i], 1'b0);
            b0[i] = busy_cnt[i];
            r0[i] = rises[i];
        end
        wr(A_DATA, 16'h00A5);
        wait_idle(100);
        cyc();
        chk("lb_rises", 0, 16'(rises[0] - r0[0]), 16'd8);
        chk("lb_rises", 1, 16'(rises[1] - r0[1]), 16'd8);
        chk("lb_busy_len", 0, 16'(busy_cnt[0] - b0[0]), 16'd32);
        chk("lb_busy_len", 1, 16'(busy_cnt[1] - b0[1]), 16'd16);
        rd_chk("lb_status", A_CTRL, 16'h000A, 16'h000A);
        rd_chk("lb_data", A_DATA, 16'h00A5, 16'h00A5);
        rd_chk("lb_status2", A_CTRL, 16'h0008, 16'h0008);

        // External slave shifting 3C.
        miso_mode = 2;
        slave_reg[0] = 8'h3C;
        slave_reg[1] = 8'h3C;
        for (int i = 0; i < 2; i++) b0[i] = busy_cnt[i];
        wr(A_DATA, 16'h00C3);
        wait_idle(100);
        cyc();
        chk("sl_busy_len", 0, 16'(busy_cnt[0] - b0[0]), 16'd32);
        chk("sl_busy_len", 1, 16'(busy_cnt[1] - b0[1]), 16'd16);
        rd_chk("sl_data", A_DATA, 16'h003C, 16'h003C);

        // Writes while busy are dropped and flag overrun.
        miso_mode = 1;
        wr(A_DATA, 16'h0011);
        wr(A_DATA, 16'h0022);
        wr(A_CTRL, 16'h0000);
        for (int i = 0; i < 2; i++) chk_bit("ov_cs_n", i, cs_n[i], 1'b0);
        wait_idle(100);
        cyc();
        rd_chk("ov_status", A_CTRL, 16'h000E, 16'h000E);
        rd_chk("ov_data", A_DATA, 16'h0011, 16'h0011);
        wr(A_CTRL, 16'h0003);
        rd_chk("ov_clear", A_CTRL, 16'h0008, 16'h0008);

        // CTRL and DATA in the same cycle.
        wr(A_CTRL, 16'h0000);
        for (int i = 0; i < 2; i++) chk_bit("sc_cs_idle", i, cs_n[i], 1'b1);
        wr(A_BOTH, 16'h00FF);
        for (int i = 0; i < 2; i++) begin
            chk_bit("sc_cs_n", i, cs_n[i], 1'b0);
            chk_bit("sc_busy", i, busy[i], 1'b1);
        end
        f0 = -1;
        f1 = -1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (sck[0] === 1'b1 && f0 < 0) f0 = k;
            if (sck[1] === 1'b1 && f1 < 0) f1 = k;
        end
        chk("sc_first_rise", 0, 16'(f0), 16'(D0));
        chk("sc_first_rise", 1, 16'(f1), 16'(D1));
        wait_idle(100);
        cyc();
        rd_chk("sc_data", A_DATA, 16'h00FF, 16'h00FF);

        // Foreign address bits.
        wr(A_B12, 16'hFFFF);
        wr(A_B2, 16'hFFFF);
        for (int i = 0; i < 2; i++) chk_bit("iso_busy", i, busy[i], 1'b0);
        rd_chk("iso_rd12", A_B12, 16'h0000, 16'h0000);
        rd_chk("iso_rd2", A_B2, 16'h0000, 16'h0000);
        rd_chk("iso_status", A_CTRL, 16'h0008, 16'h0008);

        // Random traffic against the model.
        miso_mode = 0;
        addr_tab = '{A_DATA, A_CTRL, A_BOTH, A_B12, A_B2, 16'h0000, 16'h0000};
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            io_write_enable = ($urandom_range(0, 3) == 0);
            io_read_enable = ($urandom_range(0, 2) == 0);
            io_address = addr_tab[$urandom_range(0, 5)];
            if ($urandom_range(0, 19) == 0) io_address = 16'($urandom);
            io_write_data = 16'($urandom);
            rnd_miso = 1'($urandom_range(0, 1));
            cyc();
        end
        reset = 1'b0;
        io_write_enable = 1'b0;
        io_read_enable = 1'b0;
        io_address = '0;
        wait_idle(200);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
